alu_cmd_issuer: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_cmd_issuer_sync_fifo.sv | 55 +++++
 rtl/alu_cmd_issuer.sv | 119 +++++++++++
 tb/tb_alu_cmd_issuer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcode constants and FSM states.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_cmd_issuer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; entries are only ever read when the count says they are valid.
    // NOTE: the data array is deliberately not reset -- pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
    // NOTE: non-blocking assignments here so every register samples pre-edge values, as real flops do.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Drives a combinational ALU from a command stream, waits a settle window,
// samples the result and queues it, tagged, for a downstream consumer.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int W      = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int SEQ_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic             cmd_chain,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_sel,
    input  logic [W-1:0]     alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_zero,
    output logic [SEQ_W-1:0] rsp_seq
);

    localparam int              CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int              AW          = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_CNT   = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     settle_cnt;
    logic [W-1:0]         acc;
    logic [SEQ_W-1:0]     seq;
    logic                 accept;
    logic                 sample;
    logic [AW:0]          fifo_count;
    logic                 fifo_empty;
    logic [W+SEQ_W-1:0]   fifo_head;

    assign accept = cmd_valid && cmd_ready;

    // Next-state and handshake decode: accept only when idle with FIFO room, sample when the window expires.
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst && (fifo_count < DEPTH_CNT);
                if (cmd_valid && cmd_ready) next_state = BUSY;
            end
            BUSY: begin
                if (settle_cnt == '0) begin
                    sample     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Operand launch, settle countdown, accumulator and sequence tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            seq        <= '0;
        end else begin
            if (accept) begin
                alu_a      <= cmd_chain ? acc : cmd_a;
                alu_b      <= cmd_b;
                alu_sel    <= cmd_op;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == BUSY && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
            if (sample) begin
                acc <= alu_c;
                seq <= seq + SEQ_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (W + SEQ_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (sample),
        .wr_data ({alu_c, seq}),
        .pop     (rsp_ready),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_head[W+SEQ_W-1:SEQ_W];
    assign rsp_seq   = fifo_head[SEQ_W-1:0];
    assign rsp_zero  = (rsp_data == '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed scenarios plus randomized traffic checked
// against an arithmetic reference model and an expected-response queue.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int W     = 4;
    localparam int SEQ_W = 4;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << W;
    localparam int SMOD  = 1 << SEQ_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // SETTLE=1 instance
    logic             rst, cmd_valid, cmd_ready, cmd_chain;
    logic [1:0]       cmd_op, alu_sel;
    logic [W-1:0]     cmd_a, cmd_b, alu_a, alu_b, alu_c, rsp_data;
    logic             rsp_valid, rsp_ready, rsp_zero;
    logic [SEQ_W-1:0] rsp_seq;

    // SETTLE=3 instance
    logic             rst_3, cmd_valid_3, cmd_ready_3, cmd_chain_3;
    logic [1:0]       cmd_op_3, alu_sel_3;
    logic [W-1:0]     cmd_a_3, cmd_b_3, alu_a_3, alu_b_3, alu_c_3, rsp_data_3;
    logic             rsp_valid_3, rsp_ready_3, rsp_zero_3;
    logic [SEQ_W-1:0] rsp_seq_3;

    alu_cmd_issuer #(.W(W), .DEPTH(DEPTH), .SETTLE(1), .SEQ_W(SEQ_W)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_seq(rsp_seq)
    );

    alu_cmd_issuer #(.W(W), .DEPTH(DEPTH), .SETTLE(3), .SEQ_W(SEQ_W)) u_dut3 (
        .clk(clk), .rst(rst_3), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
        .cmd_op(cmd_op_3), .cmd_a(cmd_a_3), .cmd_b(cmd_b_3), .cmd_chain(cmd_chain_3),
        .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_sel(alu_sel_3), .alu_c(alu_c_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_data(rsp_data_3),
        .rsp_zero(rsp_zero_3), .rsp_seq(rsp_seq_3)
    );

    // The combinational ALU sitting on the operand lines.
    function automatic logic [W-1:0] alu_fn(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        case (sel)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            default: return a - b;
        endcase
    endfunction

    assign alu_c   = alu_fn(alu_sel, alu_a, alu_b);
    assign alu_c_3 = alu_fn(alu_sel_3, alu_a_3, alu_b_3);

    // Reference model: integer arithmetic, accumulator, tag counter, response queue.
    typedef struct {
        int data;
        int seq;
    } rsp_t;

    rsp_t exp_q[$];
    int   m_acc    = 0;
    int   m_seq    = 0;
    int   pop_cnt  = 0;
    int   last_seq = -1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    function automatic int ref_result(input int op, input int a, input int b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return (a + b) % MOD;
            default: return (a - b + MOD) % MOD;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every response popped from the SETTLE=1 instance must match the queue head.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), e.data);
                check("rsp_seq",  32'(rsp_seq),  e.seq);
                check("rsp_zero", 32'(rsp_zero), 32'(e.data == 0));
                last_seq = e.seq;
                pop_cnt++;
            end
        end
    end

    task automatic reset_dut();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        m_acc   = 0;
        m_seq   = 0;
        pop_cnt = 0;
        #1;
    endtask

    // Present a command and hold it until accepted; returns just after the handshake edge.
    task automatic send(input int op, input int a, input int b, input bit chain, input bit rand_ready);
        int n;
        int a_eff;
        int r;
        cmd_op    = op[1:0];
        cmd_a     = a[W-1:0];
        cmd_b     = b[W-1:0];
        cmd_chain = chain;
        cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 64) begin
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        a_eff = chain ? m_acc : (a % MOD);
        r     = ref_result(op, a_eff, b % MOD);
        exp_q.push_back('{data: r, seq: m_seq});
        m_acc = r;
        m_seq = (m_seq + 1) % SMOD;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        check("drain_model_q", exp_q.size(), 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0; rsp_ready = 1'b0;
        rst_3 = 1'b1; cmd_valid_3 = 1'b0; cmd_op_3 = '0; cmd_a_3 = '0; cmd_b_3 = '0;
        cmd_chain_3 = 1'b0; rsp_ready_3 = 1'b0;

        // 1. Reset with a command pending: nothing accepted, outputs cleared.
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 4'd9; cmd_b = 4'd8;
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_b",     32'(alu_b),     32'd0);
        check("rst_alu_sel",   32'(alu_sel),   32'd0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        tick();
        check("rst_no_accept", 32'(rsp_valid), 32'd0);

        // 2. Single ADD, 9+8 wraps to 1; response two cycles after handshake.
        send(OP_ADD, 9, 8, 1'b0, 1'b0);
        check("add_alu_a",   32'(alu_a),   32'd9);
        check("add_alu_b",   32'(alu_b),   32'd8);
        check("add_alu_sel", 32'(alu_sel), 32'(OP_ADD));
        check("add_early",   32'(rsp_valid), 32'd0);
        tick();
        check("add_valid",   32'(rsp_valid), 32'd1);
        check("add_data",    32'(rsp_data),  32'd1);
        check("add_zero",    32'(rsp_zero),  32'd0);
        check("add_seq",     32'(rsp_seq),   32'd0);
        check("add_ready",   32'(cmd_ready), 32'd1);
        drain();

        // 3. Chaining: 3-5=E, E&6=6, 6-6=0.
        reset_dut();
        rsp_ready = 1'b1;
        send(OP_SUB, 3, 5, 1'b0, 1'b0);
        send(OP_AND, 0, 6, 1'b1, 1'b0);
        check("chain_acc_a", 32'(alu_a), 32'hE);
        send(OP_SUB, 0, 6, 1'b1, 1'b0);
        check("chain_acc_b", 32'(alu_a), 32'h6);
        drain();
        check("chain_pops", pop_cnt, 32'd3);

        // 4. Backpressure: four fill the FIFO, the fifth waits for one pop.
        reset_dut();
        for (int i = 0; i < 4; i++) send(OP_ADD, i, 1, 1'b0, 1'b0);
        tick();
        cmd_op = OP_ADD; cmd_a = 4'd4; cmd_b = 4'd1; cmd_chain = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_blocked", 32'(cmd_ready), 32'd0);
            tick();
        end
        check("bp_head_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_room", 32'(cmd_ready), 32'd1);
        send(OP_ADD, 4, 1, 1'b0, 1'b0);
        drain();
        check("bp_pops", pop_cnt, 32'd5);

        // 5. Seventeen ORs: tag wraps 15 -> 0; second result pushes while first pops.
        reset_dut();
        send(OP_OR, $urandom_range(0, MOD-1), $urandom_range(0, MOD-1), 1'b0, 1'b0);
        send(OP_OR, $urandom_range(0, MOD-1), $urandom_range(0, MOD-1), 1'b0, 1'b0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            send(OP_OR, $urandom_range(0, MOD-1), $urandom_range(0, MOD-1), 1'b0, 1'b0);
        drain();
        check("wrap_pops", pop_cnt, 32'd17);
        check("wrap_last_seq", last_seq, 32'd0);

        // Randomized traffic with random backpressure and chaining.
        reset_dut();
        for (int i = 0; i < 60; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            send($urandom_range(0, 3), $urandom_range(0, MOD-1), $urandom_range(0, MOD-1),
                 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        check("rand_pops", pop_cnt, 32'd60);

        // 6. SETTLE=3: reset in the 2nd BUSY cycle discards the command.
        tick();
        rst_3 = 1'b0;
        #1;
        check("s3_ready", 32'(cmd_ready_3), 32'd1);
        cmd_op_3 = OP_ADD; cmd_a_3 = 4'd2; cmd_b_3 = 4'd3; cmd_chain_3 = 1'b0; cmd_valid_3 = 1'b1;
        tick();
        cmd_valid_3 = 1'b0;
        check("s3_alu_a", 32'(alu_a_3), 32'd2);
        tick();
        rst_3 = 1'b1;
        tick();
        rst_3 = 1'b0;
        #1;
        check("s3_rst_ready", 32'(cmd_ready_3), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("s3_no_rsp", 32'(rsp_valid_3), 32'd0);
            tick();
        end
        cmd_op_3 = OP_ADD; cmd_a_3 = 4'd9; cmd_b_3 = 4'd5; cmd_chain_3 = 1'b1; cmd_valid_3 = 1'b1;
        tick();
        cmd_valid_3 = 1'b0;
        check("s3_chain_a", 32'(alu_a_3), 32'd0);
        check("s3_chain_b", 32'(alu_b_3), 32'd5);
        tick();
        check("s3_settle1", 32'(rsp_valid_3), 32'd0);
        tick();
        check("s3_settle2", 32'(rsp_valid_3), 32'd0);
        tick();
        check("s3_valid", 32'(rsp_valid_3), 32'd1);
        check("s3_data",  32'(rsp_data_3),  32'd5);
        check("s3_seq",   32'(rsp_seq_3),   32'd0);
        check("s3_zero",  32'(rsp_zero_3),  32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
